// File: rtl/line_follow_pkg.sv
// Shared encodings for the line-follow steering sequencer: FSM states,
// sensor patterns ([2]=left, [1]=centre, [0]=right), motor direction levels.
package line_follow_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FORWARD = 3'd1,
      ST_LEFT    = 3'd2,
      ST_RIGHT   = 3'd3,
      ST_LOST    = 3'd4,
      ST_SEARCH  = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   localparam logic [2:0] SNS_NONE    = 3'b000;
   localparam logic [2:0] SNS_RIGHT   = 3'b001;
   localparam logic [2:0] SNS_CENTRE  = 3'b010;
   localparam logic [2:0] SNS_RIGHT_C = 3'b011;
   localparam logic [2:0] SNS_LEFT    = 3'b100;
   localparam logic [2:0] SNS_SPLIT   = 3'b101;
   localparam logic [2:0] SNS_LEFT_C  = 3'b110;
   localparam logic [2:0] SNS_ALL     = 3'b111;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   // Steering decision for a running (non-HALT) state; timeouts are layered on top.
   function automatic state_t sensor_decode(input state_t cur, input logic [2:0] sensor);
      state_t nxt;
      nxt = cur;
      case (sensor)
         SNS_CENTRE, SNS_ALL:    nxt = ST_FORWARD;
         SNS_LEFT, SNS_LEFT_C:   nxt = ST_LEFT;
         SNS_RIGHT, SNS_RIGHT_C: nxt = ST_RIGHT;
         SNS_NONE:               nxt = (cur == ST_LOST || cur == ST_SEARCH) ? cur : ST_LOST;
         SNS_SPLIT:              nxt = (cur == ST_IDLE) ? ST_FORWARD : cur;
         default:                nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/line_follow_controller_motor_pwm.sv
// One motor channel: free-running period counter, duty/direction latched at
// the wrap cycle, and an immediate force-off for stopped states.
module motor_pwm
   import line_follow_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [PWM_BITS:0]   DutyCmd,
   input  logic                DirCmd,
   input  logic                ForceOff,
   output logic                Pwm,
   output logic                Dir
);

   logic [PWM_BITS-1:0] cnt;
   logic [PWM_BITS:0]   duty_active;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cnt         <= '0;
         duty_active <= '0;
         Dir         <= DIR_FWD;
      end else begin
         cnt <= cnt + 1'b1;
         if (cnt == '1) begin
            duty_active <= ForceOff ? '0 : DutyCmd;
            Dir         <= DirCmd;
         end else if (ForceOff) begin
            duty_active <= '0;
         end
      end
   end

   // Duty carries one extra bit so a full-scale value yields constant high.
   assign Pwm = !ForceOff && ({1'b0, cnt} < duty_active);

endmodule

// File: rtl/line_follow_controller.sv
// Line-following drive FSM feeding two motor_pwm channels.
// Optional macro LINE_SEARCH_EN: LOST timeout enters a SEARCH spin instead of HALT.
module line_follow_controller
   import line_follow_pkg::*;
#(
   parameter int unsigned PWM_BITS       = 8,
   parameter int unsigned FWD_DUTY       = 200,
   parameter int unsigned TURN_DUTY      = 120,
   parameter int unsigned LOST_TIMEOUT   = 1000,
   parameter int unsigned SEARCH_TIMEOUT = 5000,
   parameter int unsigned TMR_BITS       = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [2:0] Sensor,
   output logic       LeftPwm,
   output logic       RightPwm,
   output logic       LeftDir,
   output logic       RightDir,
   output logic [2:0] State,
   output logic       Lost
);

   localparam int unsigned PWM_FULL = 2 ** PWM_BITS;
   localparam logic [PWM_BITS:0] FWD_CMD  = (FWD_DUTY  >= PWM_FULL) ? (PWM_BITS+1)'(PWM_FULL)
                                                                    : (PWM_BITS+1)'(FWD_DUTY);
   localparam logic [PWM_BITS:0] TURN_CMD = (TURN_DUTY >= PWM_FULL) ? (PWM_BITS+1)'(PWM_FULL)
                                                                    : (PWM_BITS+1)'(TURN_DUTY);
   localparam logic [TMR_BITS-1:0] LOST_LAST = TMR_BITS'(LOST_TIMEOUT - 1);
`ifdef LINE_SEARCH_EN
   localparam logic [TMR_BITS-1:0] SEARCH_LAST = TMR_BITS'(SEARCH_TIMEOUT - 1);
`endif

   state_t              state;
   state_t              next;
   logic [TMR_BITS-1:0] timer;
   logic                last_side;

   logic [PWM_BITS:0]   cmd_l_duty, cmd_r_duty;
   logic                cmd_l_dir, cmd_r_dir;
   logic [PWM_BITS:0]   hold_l_duty, hold_r_duty;
   logic                hold_l_dir, hold_r_dir;
   logic                force_off;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         timer     <= '0;
         last_side <= 1'b0;
         Lost      <= 1'b0;
      end else begin
         state <= next;
         if (next != state)
            timer <= '0;
         else if (state == ST_LOST || state == ST_SEARCH)
            timer <= timer + 1'b1;
         else
            timer <= '0;
         if (state == ST_LEFT)
            last_side <= 1'b1;
         else if (state == ST_RIGHT)
            last_side <= 1'b0;
         if (next == ST_HALT)
            Lost <= 1'b1;
         else if (next == ST_IDLE)
            Lost <= 1'b0;
      end
   end

   // Timeouts only fire when the sensor decode would keep the current state.
   always_comb begin
      next = state;
      if (!Enable) begin
         next = ST_IDLE;
      end else if (state != ST_HALT) begin
         next = sensor_decode(state, Sensor);
         if (next == state) begin
            if (state == ST_LOST && timer == LOST_LAST)
`ifdef LINE_SEARCH_EN
               next = ST_SEARCH;
            if (state == ST_SEARCH && timer == SEARCH_LAST)
               next = ST_HALT;
`else
               next = ST_HALT;
`endif
         end
      end
   end

   always_comb begin
      cmd_l_duty = '0;
      cmd_r_duty = '0;
      cmd_l_dir  = DIR_FWD;
      cmd_r_dir  = DIR_FWD;
      case (state)
         ST_FORWARD: begin
            cmd_l_duty = FWD_CMD;
            cmd_r_duty = FWD_CMD;
         end
         ST_LEFT:  cmd_r_duty = TURN_CMD;
         ST_RIGHT: cmd_l_duty = TURN_CMD;
         ST_LOST: begin
            cmd_l_duty = hold_l_duty;
            cmd_r_duty = hold_r_duty;
            cmd_l_dir  = hold_l_dir;
            cmd_r_dir  = hold_r_dir;
         end
`ifdef LINE_SEARCH_EN
         ST_SEARCH: begin
            cmd_l_duty = TURN_CMD;
            cmd_r_duty = TURN_CMD;
            cmd_l_dir  = last_side ? DIR_FWD : DIR_REV;
            cmd_r_dir  = last_side ? DIR_REV : DIR_FWD;
         end
`endif
         default: ;
      endcase
   end

   // Last commanded values, replayed unchanged while LOST.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hold_l_duty <= '0;
         hold_r_duty <= '0;
         hold_l_dir  <= DIR_FWD;
         hold_r_dir  <= DIR_FWD;
      end else begin
         hold_l_duty <= cmd_l_duty;
         hold_r_duty <= cmd_r_duty;
         hold_l_dir  <= cmd_l_dir;
         hold_r_dir  <= cmd_r_dir;
      end
   end

   assign force_off = (state == ST_IDLE) || (state == ST_HALT);
   assign State     = state;

   motor_pwm #(.PWM_BITS(PWM_BITS)) u_left_motor (
      .Clock    (Clock),
      .Reset    (Reset),
      .DutyCmd  (cmd_l_duty),
      .DirCmd   (cmd_l_dir),
      .ForceOff (force_off),
      .Pwm      (LeftPwm),
      .Dir      (LeftDir)
   );

   motor_pwm #(.PWM_BITS(PWM_BITS)) u_right_motor (
      .Clock    (Clock),
      .Reset    (Reset),
      .DutyCmd  (cmd_r_duty),
      .DirCmd   (cmd_r_dir),
      .ForceOff (force_off),
      .Pwm      (RightPwm),
      .Dir      (RightDir)
   );

endmodule
